// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle: raw button levels in, debounced levels and
// single-cycle step pulses out toward the cursor-position stage.
interface button_conditioner_if;
    logic       btnU;
    logic       btnD;
    logic       btnL;
    logic       btnR;
    logic [3:0] held;
    logic       step_up;
    logic       step_down;
    logic       step_left;
    logic       step_right;

    // Drives the raw buttons and consumes the conditioned outputs.
    modport master (
        output btnU, btnD, btnL, btnR,
        input  held, step_up, step_down, step_left, step_right
    );

    // The conditioner itself.
    modport slave (
        input  btnU, btnD, btnL, btnR,
        output held, step_up, step_down, step_left, step_right
    );
endinterface

// File: rtl/button_conditioner.sv
// Four-channel push-button conditioner: 2-flop synchroniser, debouncer and a
// typematic auto-repeat FSM per button, with opposite-direction pulse masking.
// Channel order everywhere is {R,L,D,U}: bit 0 is U, bit 3 is R.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input logic                 clk,
    input logic                 reset,
    button_conditioner_if.slave bus
);

    localparam int unsigned DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                     : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DELAY  = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;

    logic [3:0]       raw;
    logic [3:0]       sync1_q;
    logic [3:0]       sync_q;
    logic [3:0]       held_q;
    logic [3:0]       held_d;
    logic [DB_W-1:0]  db_cnt_q  [4];
    logic [DB_W-1:0]  db_cnt_d  [4];
    logic [1:0]       state_q   [4];
    logic [1:0]       state_d   [4];
    logic [RPT_W-1:0] rpt_cnt_q [4];
    logic [RPT_W-1:0] rpt_cnt_d [4];
    logic [3:0]       raw_pulse;
    logic [3:0]       step_q;
    logic [3:0]       step_d;
    logic             both_ud;
    logic             both_lr;

    assign raw = {bus.btnR, bus.btnL, bus.btnD, bus.btnU};

    // Debounce: accept a level change only after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        held_d = held_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync_q[i] != held_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    held_d[i] = ~held_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Repeat FSMs: initial pulse on acceptance, first repeat after the delay, then periodic.
    // Decisions use held_d so a release accepted this edge suppresses any pulse on it.
    always_comb begin
        raw_pulse = '0;
        for (int i = 0; i < 4; i++) begin
            state_d[i]   = state_q[i];
            rpt_cnt_d[i] = rpt_cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (held_d[i] && !held_q[i]) begin
                        raw_pulse[i] = 1'b1;
                        rpt_cnt_d[i] = '0;
                        state_d[i]   = DELAY;
                    end
                end
                DELAY: begin
                    if (!held_d[i]) begin
                        rpt_cnt_d[i] = '0;
                        state_d[i]   = IDLE;
                    end else if (rpt_cnt_q[i] == DELAY_LAST) begin
                        raw_pulse[i] = 1'b1;
                        rpt_cnt_d[i] = '0;
                        state_d[i]   = REPEAT;
                    end else begin
                        rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                    end
                end
                REPEAT: begin
                    if (!held_d[i]) begin
                        rpt_cnt_d[i] = '0;
                        state_d[i]   = IDLE;
                    end else if (rpt_cnt_q[i] == PERIOD_LAST) begin
                        raw_pulse[i] = 1'b1;
                        rpt_cnt_d[i] = '0;
                    end else begin
                        rpt_cnt_d[i] = rpt_cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    rpt_cnt_d[i] = '0;
                    state_d[i]   = IDLE;
                end
            endcase
        end
    end

    // Opposite-direction mask, evaluated on the levels that become visible with the pulse.
    always_comb begin
        both_ud = held_d[0] & held_d[1];
        both_lr = held_d[2] & held_d[3];
        step_d  = {raw_pulse[3] & ~both_lr, raw_pulse[2] & ~both_lr,
                   raw_pulse[1] & ~both_ud, raw_pulse[0] & ~both_ud};
    end

    // State registers; reset discards any press in progress.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync_q  <= '0;
            held_q  <= '0;
            step_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i]  <= '0;
                state_q[i]   <= IDLE;
                rpt_cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= raw;
            sync_q  <= sync1_q;
            held_q  <= held_d;
            step_q  <= step_d;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i]  <= db_cnt_d[i];
                state_q[i]   <= state_d[i];
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
        end
    end

    assign bus.held       = held_q;
    assign bus.step_up    = step_q[0];
    assign bus.step_down  = step_q[1];
    assign bus.step_left  = step_q[2];
    assign bus.step_right = step_q[3];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. Expected held changes and step pulses are queued with the
// absolute cycle they must appear in; a negedge monitor compares every cycle.
module tb_button_conditioner;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 10;
    localparam int unsigned RP = 3;
    localparam int          NEVER = 1 << 30;

    typedef struct {
        int         cyc;
        logic [3:0] bits;
    } pulse_t;

    typedef struct {
        int   cyc;
        int   ch;
        logic val;
    } held_ev_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    int   matched_p;
    int   matched_h;

    pulse_t     pulse_q [$];
    held_ev_t   held_q  [$];
    logic [3:0] exp_step;
    logic [3:0] exp_held;
    logic [3:0] obs_step;

    button_conditioner_if bus ();

    button_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Queue one channel's activity: held rises at 'rise', pulses at rise, rise+RD,
    // rise+RD+k*RP strictly before 'stop' (and not before emit_from), held falls at stop.
    task automatic push_chan(input int ch, input int rise, input int stop,
                             input int emit_from, input bit push_fall);
        int p;
        held_ev_t h;
        pulse_t   e;
        h.cyc = rise; h.ch = ch; h.val = 1'b1;
        held_q.push_back(h);
        if (push_fall) begin
            h.cyc = stop; h.ch = ch; h.val = 1'b0;
            held_q.push_back(h);
        end
        p = rise;
        while (p < stop) begin
            if (p >= emit_from) begin
                e.cyc  = p;
                e.bits = 4'b0001 << ch;
                pulse_q.push_back(e);
            end
            p = (p == rise) ? rise + RD : p + RP;
        end
    endtask

    // Scoreboard monitor, sampling away from the active edge.
    initial begin
        exp_held  = '0;
        matched_p = 0;
        matched_h = 0;
        forever begin
            @(negedge clk);
            exp_step = '0;
            foreach (pulse_q[i]) begin
                if (pulse_q[i].cyc == cyc) begin
                    exp_step = exp_step | pulse_q[i].bits;
                    matched_p++;
                end
            end
            if (!reset) exp_held = '0;
            foreach (held_q[i]) begin
                if (held_q[i].cyc == cyc) begin
                    exp_held[held_q[i].ch] = held_q[i].val;
                    matched_h++;
                end
            end
            obs_step = {bus.step_right, bus.step_left, bus.step_down, bus.step_up};
            checks++;
            assert (obs_step === exp_step) else begin
                errors++;
                $error("FAIL step cyc=%0d observed=%b expected=%b", cyc, obs_step, exp_step);
            end
            checks++;
            assert (bus.held === exp_held) else begin
                errors++;
                $error("FAIL held cyc=%0d observed=%b expected=%b", cyc, bus.held, exp_held);
            end
        end
    end

    initial begin
        int t;
        int u;
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.btnU = 1'b0;
        bus.btnD = 1'b0;
        bus.btnL = 1'b0;
        bus.btnR = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Clean press of U for 30 cycles.
        t = cyc;
        bus.btnU = 1'b1;
        push_chan(0, t + 6, t + 36, 0, 1'b1);
        repeat (30) @(negedge clk);
        bus.btnU = 1'b0;
        repeat (15) @(negedge clk);

        // Bouncing press and bouncing release on L.
        t = cyc;
        bus.btnL = 1'b1;
        push_chan(2, t + 14, t + 30, 0, 1'b1);
        repeat (2) @(negedge clk);
        bus.btnL = 1'b0;
        repeat (2) @(negedge clk);
        bus.btnL = 1'b1;
        repeat (2) @(negedge clk);
        bus.btnL = 1'b0;
        repeat (2) @(negedge clk);
        bus.btnL = 1'b1;
        repeat (12) @(negedge clk);
        bus.btnL = 1'b0;
        repeat (2) @(negedge clk);
        bus.btnL = 1'b1;
        repeat (2) @(negedge clk);
        bus.btnL = 1'b0;
        repeat (15) @(negedge clk);

        // U and D together: both masked until D is released, then U resumes.
        t = cyc;
        bus.btnU = 1'b1;
        bus.btnD = 1'b1;
        push_chan(0, t + 6, t + 36, t + 26, 1'b1);
        push_chan(1, t + 6, t + 26, NEVER, 1'b1);
        repeat (20) @(negedge clk);
        bus.btnD = 1'b0;
        repeat (10) @(negedge clk);
        bus.btnU = 1'b0;
        repeat (15) @(negedge clk);

        // Diagonal U+R: both channels pulse together.
        t = cyc;
        bus.btnU = 1'b1;
        bus.btnR = 1'b1;
        push_chan(0, t + 6, t + 26, 0, 1'b1);
        push_chan(3, t + 6, t + 26, 0, 1'b1);
        repeat (20) @(negedge clk);
        bus.btnU = 1'b0;
        bus.btnR = 1'b0;
        repeat (15) @(negedge clk);

        // Reset asserted between edges while R is pulsing in REPEAT.
        t = cyc;
        bus.btnR = 1'b1;
        push_chan(3, t + 6, t + 23, 0, 1'b0);
        repeat (22) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checks++;
        assert (bus.held === 4'b0000) else begin
            errors++;
            $error("FAIL async_reset_held observed=%b expected=%b", bus.held, 4'b0000);
        end
        checks++;
        assert (bus.step_right === 1'b0) else begin
            errors++;
            $error("FAIL async_reset_step observed=%b expected=%b", bus.step_right, 1'b0);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        u = cyc;
        push_chan(3, u + 6, u + 18, 0, 1'b1);
        repeat (12) @(negedge clk);
        bus.btnR = 1'b0;
        repeat (15) @(negedge clk);

        // Glitch on D three cycles long: never accepted.
        bus.btnD = 1'b1;
        repeat (3) @(negedge clk);
        bus.btnD = 1'b0;
        repeat (15) @(negedge clk);

        // Every queued event must have been reached.
        checks++;
        assert (matched_p === pulse_q.size()) else begin
            errors++;
            $error("FAIL pulse_events observed=%0d expected=%0d", matched_p, pulse_q.size());
        end
        checks++;
        assert (matched_h === held_q.size()) else begin
            errors++;
            $error("FAIL held_events observed=%0d expected=%0d", matched_h, held_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
